// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - MIPS-style instruction word encoder feeding a DEPTH-entry output FIFO.
// Optional macro INST_ENCODER_IMM_CHECK_EN adds a per-entry immediate range error flag.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [5:0]               op,
  input  logic [5:0]               func,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               sa,
  input  logic [31:0]              imm32,
  input  logic                     imm_is_br,
  input  logic                     imm_zx,
  input  logic [25:0]              instr_index,
  input  logic [2:0]               sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   word_d;
  logic [15:0]   imm16;
  logic          push, pop;

  // Branch offsets are byte offsets; the word field drops the two alignment bits.
  always_comb begin
    imm16 = imm_is_br ? imm32[17:2] : imm32[15:0];
    case (fmt)
      2'd0:    word_d = {op, rs, rt, rd, sa, func};
      2'd1:    word_d = {op, rs, rt, imm16};
      2'd2:    word_d = {op, instr_index};
      default: word_d = {op, rs, rt, rd, 8'b0, sel};
    endcase
  end

  always_comb begin
    in_ready  = count_q < DEPTH_C;
    out_valid = count_q != '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uncleared by reset; head contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= word_d;
  end

  assign out_inst = mem_q[rd_ptr_q];
  assign count    = count_q;

`ifdef INST_ENCODER_IMM_CHECK_EN
  logic err_mem_q [DEPTH];
  logic err_d;

  always_comb begin
    err_d = 1'b0;
    if (fmt == 2'd1) begin
      if (imm_is_br)
        err_d = (imm32[1:0] != 2'b00) || (imm32[31:17] != {15{imm32[17]}});
      else if (imm_zx)
        err_d = imm32[31:16] != 16'h0000;
      else
        err_d = imm32[31:16] != {16{imm32[15]}};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) err_mem_q[wr_ptr_q] <= err_d;
  end

  assign out_err = err_mem_q[rd_ptr_q];
`else
  logic unused_imm_bits;
  assign unused_imm_bits = ^{imm_zx, imm32[31:18]};
  assign out_err = 1'b0;
`endif

endmodule
